// File: rtl/uplink_sequencer.sv
// uplink_sequencer: queues 15-bit uplink words and serializes them MSB-first
// as UPL1 (one) / UPL0 (zero) pulses separated by idle gaps, honouring the
// AGC uplink block input between bits.
module uplink_sequencer #(
    parameter int PULSE_CYC  = 20,
    parameter int GAP_CYC    = 80,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        SIM_CLK,
    input  logic        SIM_RST_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        raw_mode,
    input  logic [14:0] in_data,
    input  logic        BLKUPL_n,
    input  logic        abort,
    output logic        UPL0,
    output logic        UPL1,
    output logic        busy,
    output logic        word_done,
    output logic        overflow
);

    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int MAX_CYC = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int CYC_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [CYC_W-1:0] PULSE_END = CYC_W'(PULSE_CYC - 1);
    localparam logic [CYC_W-1:0] GAP_END   = CYC_W'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Keycodes are sent three times, the middle copy inverted, so the AGC
    // can detect corruption; raw words go out untouched.
    function automatic logic [14:0] expand_word(input logic        raw,
                                                input logic [14:0] data);
        logic [4:0] key;
        key = data[4:0];
        if (raw) begin
            return data;
        end
        return {key, ~key, key};
    endfunction

    state_t             state_q, state_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic [14:0]        shift_q, shift_d;
    logic               upl0_q, upl0_d;
    logic               upl1_q, upl1_d;
    logic               word_done_q, word_done_d;
    logic               overflow_q, overflow_d;

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [14:0]        mem_q [FIFO_DEPTH];

    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic [14:0]        wr_word;
    logic [14:0]        head;

    assign full      = (count_q == CNT_FULL);
    assign empty     = (count_q == '0);
    assign in_ready  = ~full;
    assign head      = mem_q[rd_ptr_q];
    assign wr_word   = expand_word(raw_mode, in_data);

    // A refused push never sneaks in on a same-cycle pop, and abort discards
    // anything offered alongside it.
    assign push      = in_valid & ~full & ~abort;
    assign pop       = (state_q == IDLE) & ~empty & BLKUPL_n & ~abort;

    assign busy      = (state_q != IDLE);
    assign UPL0      = upl0_q;
    assign UPL1      = upl1_q;
    assign word_done = word_done_q;
    assign overflow  = overflow_q;

    // FIFO pointer/occupancy bookkeeping and the sticky overflow flag.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (abort) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (in_valid && full) begin
                overflow_d = 1'b1;
            end
            if (push) begin
                wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Serializer FSM: next state, bit bookkeeping and next pulse levels.
    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        upl0_d      = 1'b0;
        upl1_d      = 1'b0;
        word_done_d = 1'b0;
        if (abort) begin
            state_d = IDLE;
            cyc_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        shift_d   = head;
                        bit_cnt_d = 4'd14;
                        cyc_d     = '0;
                        state_d   = PULSE;
                        upl1_d    = head[14];
                        upl0_d    = ~head[14];
                    end
                end
                PULSE: begin
                    // The line level is held for the whole pulse; the block
                    // input is deliberately ignored here.
                    if (cyc_q == PULSE_END) begin
                        cyc_d   = '0;
                        state_d = GAP;
                    end else begin
                        cyc_d  = cyc_q + CYC_W'(1);
                        upl1_d = shift_q[14];
                        upl0_d = ~shift_q[14];
                    end
                end
                GAP: begin
                    // The counter parks on its last value while blocked, so
                    // the next bit starts the cycle after the block lifts.
                    if (cyc_q != GAP_END) begin
                        cyc_d = cyc_q + CYC_W'(1);
                    end else if (bit_cnt_q == 4'd0) begin
                        cyc_d       = '0;
                        word_done_d = 1'b1;
                        state_d     = IDLE;
                    end else if (BLKUPL_n) begin
                        shift_d   = {shift_q[13:0], 1'b0};
                        bit_cnt_d = bit_cnt_q - 4'd1;
                        cyc_d     = '0;
                        state_d   = PULSE;
                        upl1_d    = shift_q[13];
                        upl0_d    = ~shift_q[13];
                    end
                end
                default: begin
                    state_d = IDLE;
                    cyc_d   = '0;
                end
            endcase
        end
    end

    // Control and output registers; reset drops the lines asynchronously
    // and forgets any queued or partially sent word.
    always_ff @(posedge SIM_CLK or negedge SIM_RST_n) begin
        if (!SIM_RST_n) begin
            state_q     <= IDLE;
            cyc_q       <= '0;
            bit_cnt_q   <= 4'd0;
            upl0_q      <= 1'b0;
            upl1_q      <= 1'b0;
            word_done_q <= 1'b0;
            overflow_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            bit_cnt_q   <= bit_cnt_d;
            upl0_q      <= upl0_d;
            upl1_q      <= upl1_d;
            word_done_q <= word_done_d;
            overflow_q  <= overflow_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Word storage and shift register carry data only; their contents are
    // meaningless until the control state says otherwise.
    always_ff @(posedge SIM_CLK) begin
        shift_q <= shift_d;
        if (push) begin
            mem_q[wr_ptr_q] <= wr_word;
        end
    end

endmodule

// File: tb/tb_uplink_sequencer.sv
// Directed bench for uplink_sequencer: logs every uplink pulse and word_done
// strobe, then compares the log against hand-computed expectations.
module tb_uplink_sequencer;

    localparam int PULSE_CYC  = 20;
    localparam int GAP_CYC    = 80;
    localparam int FIFO_DEPTH = 4;

    logic        SIM_CLK   = 1'b0;
    logic        SIM_RST_n = 1'b0;
    logic        in_valid  = 1'b0;
    logic        raw_mode  = 1'b0;
    logic [14:0] in_data   = '0;
    logic        BLKUPL_n  = 1'b1;
    logic        abort     = 1'b0;
    logic        in_ready, UPL0, UPL1, busy, word_done, overflow;

    uplink_sequencer #(
        .PULSE_CYC (PULSE_CYC),
        .GAP_CYC   (GAP_CYC),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .SIM_CLK  (SIM_CLK),
        .SIM_RST_n(SIM_RST_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .raw_mode (raw_mode),
        .in_data  (in_data),
        .BLKUPL_n (BLKUPL_n),
        .abort    (abort),
        .UPL0     (UPL0),
        .UPL1     (UPL1),
        .busy     (busy),
        .word_done(word_done),
        .overflow (overflow)
    );

    always #5 SIM_CLK = ~SIM_CLK;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge SIM_CLK) cyc <= cyc + 1;

    // Pulse log: start cycle, width and bit value of every completed pulse.
    int p_start[$];
    int p_width[$];
    int p_bit[$];
    int wd_cyc[$];
    int cur_start = 0;
    int cur_bit   = 0;
    int both_hi   = 0;
    logic prev_any = 1'b0;

    always @(negedge SIM_CLK) begin
        if (UPL0 && UPL1) both_hi++;
        if ((UPL0 || UPL1) && !prev_any) begin
            cur_start = cyc;
            cur_bit   = int'(UPL1);
        end
        if (!(UPL0 || UPL1) && prev_any) begin
            p_start.push_back(cur_start);
            p_width.push_back(cyc - cur_start);
            p_bit.push_back(cur_bit);
        end
        if (word_done) wd_cyc.push_back(cyc);
        prev_any = UPL0 || UPL1;
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge SIM_CLK);
        #1;
    endtask

    task automatic clear_log();
        p_start.delete();
        p_width.delete();
        p_bit.delete();
        wd_cyc.delete();
    endtask

    task automatic push(input logic raw, input logic [14:0] data, output int c);
        in_valid = 1'b1;
        raw_mode = raw;
        in_data  = data;
        c = cyc;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int n, input int budget, input string tag);
        int k = 0;
        while (wd_cyc.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk({tag, "_in_time"}, longint'(k < budget), 1);
    endtask

    task automatic wait_pulse_active(input int done_pulses, input int budget, input string tag);
        int k = 0;
        while (!(p_bit.size() == done_pulses && (UPL0 || UPL1)) && k < budget) begin
            tick();
            k++;
        end
        chk({tag, "_in_time"}, longint'(k < budget), 1);
    endtask

    function automatic int pack_bits(input int base);
        int v = 0;
        for (int i = 0; i < 15; i++) begin
            if (base + i < p_bit.size()) v = (v << 1) | p_bit[base + i];
            else v = v << 1;
        end
        return v;
    endfunction

    function automatic int bad_widths();
        int n = 0;
        foreach (p_width[i]) if (p_width[i] != PULSE_CYC) n++;
        return n;
    endfunction

    function automatic int bad_spacing(input int first, input int last);
        int n = 0;
        for (int i = first; i < last && i + 1 < p_start.size(); i++)
            if (p_start[i + 1] - p_start[i] != PULSE_CYC + GAP_CYC) n++;
        return n;
    endfunction

    initial begin
        int c0, c1, r, n;

        // Reset state
        repeat (3) tick();
        chk("rst_upl0", UPL0, 0);
        chk("rst_upl1", UPL1, 0);
        chk("rst_busy", busy, 0);
        chk("rst_word_done", word_done, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_in_ready", in_ready, 1);
        SIM_RST_n = 1'b1;
        repeat (3) tick();

        // Keycode 10101 expanded to {K,~K,K}
        clear_log();
        push(1'b0, 15'h0015, c0);
        tick();
        chk("kc_busy", busy, 1);
        wait_done(1, 2000, "kc_done");
        tick();
        chk("kc_npulses", p_bit.size(), 15);
        chk("kc_pattern", pack_bits(0), 15'b101010101010101);
        chk("kc_first_rise", p_start.size() > 0 ? p_start[0] - c0 : -1, 2);
        chk("kc_widths", bad_widths(), 0);
        chk("kc_spacing", bad_spacing(0, 14), 0);
        chk("kc_done_time", (wd_cyc.size() > 0 && p_start.size() > 0) ? wd_cyc[0] - p_start[0] : -1, 1500);
        chk("kc_idle_after", busy, 0);

        // Raw all-ones then all-zeros, back to back
        clear_log();
        both_hi = 0;
        push(1'b1, 15'h7FFF, c0);
        push(1'b1, 15'h0000, c1);
        wait_done(2, 4000, "raw_done");
        tick();
        chk("raw_npulses", p_bit.size(), 30);
        chk("raw_word0", pack_bits(0), 15'h7FFF);
        chk("raw_word1", pack_bits(15), 15'h0000);
        chk("raw_interword", p_start.size() >= 16 ? p_start[15] - p_start[14] : -1, PULSE_CYC + GAP_CYC + 1);
        chk("raw_widths", bad_widths(), 0);
        chk("raw_both_high", both_hi, 0);

        // Block before a word starts, then during bit 3's pulse
        clear_log();
        BLKUPL_n = 1'b0;
        push(1'b1, 15'h5A5A, c0);
        repeat (30) tick();
        chk("blk_start_busy", busy, 0);
        chk("blk_start_pulses", p_start.size() + int'(prev_any), 0);
        BLKUPL_n = 1'b1;
        wait_pulse_active(2, 400, "blk_bit3");
        repeat (5) tick();
        BLKUPL_n = 1'b0;
        repeat (300) tick();
        chk("blk_held_pulses", p_start.size(), 3);
        chk("blk_bit3_width", p_width.size() >= 3 ? p_width[2] : -1, PULSE_CYC);
        chk("blk_lines_low", UPL0 | UPL1, 0);
        r = cyc;
        BLKUPL_n = 1'b1;
        wait_done(1, 2000, "blk_done");
        chk("blk_bit4_start", p_start.size() >= 4 ? p_start[3] - r : -1, 1);
        chk("blk_pattern", pack_bits(0), 15'h5A5A);
        chk("blk_widths", bad_widths(), 0);

        // Six consecutive pushes: five accepted, sixth overflows
        repeat (3) tick();
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            raw_mode = 1'b0;
            in_data  = 15'(i + 1);
            chk($sformatf("fill_ready%0d", i), in_ready, (i < 5) ? 1 : 0);
            tick();
        end
        in_valid = 1'b0;
        chk("ovf_set", overflow, 1);
        repeat (10) tick();
        chk("ovf_sticky", overflow, 1);
        chk("ovf_not_ready", in_ready, 0);
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = 15'h0011;
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("abort_ovf_clr", overflow, 0);
        chk("abort_ready", in_ready, 1);
        chk("abort_busy", busy, 0);
        chk("abort_lines", UPL0 | UPL1, 0);
        repeat (5) tick();
        chk("abort_push_dropped", busy, 0);

        // Abort during bit 7 with two words queued
        clear_log();
        push(1'b1, 15'h7FFF, c0);
        push(1'b1, 15'h1234, c1);
        push(1'b1, 15'h4321, c1);
        wait_pulse_active(6, 1000, "ab7_bit7");
        repeat (4) tick();
        n = p_start.size();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab7_upl0", UPL0, 0);
        chk("ab7_upl1", UPL1, 0);
        chk("ab7_busy", busy, 0);
        chk("ab7_ready", in_ready, 1);
        repeat (300) tick();
        chk("ab7_no_more", p_start.size(), n + 1);
        chk("ab7_no_done", wd_cyc.size(), 0);
        chk("ab7_idle", busy, 0);

        // Asynchronous reset mid-pulse
        clear_log();
        push(1'b1, 15'h7FFF, c0);
        wait_pulse_active(1, 400, "rstp_bit2");
        @(negedge SIM_CLK);
        #2;
        SIM_RST_n = 1'b0;
        #1;
        chk("rstp_upl1_async", UPL1, 0);
        chk("rstp_upl0_async", UPL0, 0);
        chk("rstp_busy", busy, 0);
        repeat (2) tick();
        SIM_RST_n = 1'b1;
        clear_log();
        repeat (300) tick();
        chk("rstp_no_resume", p_start.size() + int'(prev_any), 0);
        chk("rstp_idle", busy, 0);
        push(1'b0, 15'h001F, c0);
        wait_done(1, 2000, "rstp_new");
        chk("rstp_new_rise", p_start.size() > 0 ? p_start[0] - c0 : -1, 2);
        chk("rstp_new_pattern", pack_bits(0), 15'b111110000011111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uplink_sequencer.md
UPLINK_SEQUENCER -- requirements
Module: uplink_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clock SIM_CLK, reset SIM_RST_n.
REQ-002 The block SHALL have parameter PULSE_CYC, default 20: SIM_CLK cycles each UPL0/UPL1 pulse is held high.
REQ-003 The block SHALL have parameter GAP_CYC, default 80: SIM_CLK cycles both uplink lines are low after each pulse.
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 4: number of queued 15-bit uplink words.
REQ-005 The block SHALL have port SIM_CLK, input, 1 bit: system clock.
REQ-006 The block SHALL have port SIM_RST_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port in_valid, input, 1 bit: a word is offered.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the FIFO accepts a word.
REQ-009 The block SHALL have port raw_mode, input, 1 bit: 1 means send in_data[14:0] unchanged; 0 means expand a keycode.
REQ-010 The block SHALL have port in_data, input, 15 bits: raw word, or keycode in bits [4:0].
REQ-011 The block SHALL have port BLKUPL_n, input, 1 bit: AGC uplink block, active-low; it stalls bit issue.
REQ-012 The block SHALL have port abort, input, 1 bit: synchronous flush.
REQ-013 The block SHALL have port UPL0, output, 1 bit: zero-bit pulse to the AGC.
REQ-014 The block SHALL have port UPL1, output, 1 bit: one-bit pulse to the AGC.
REQ-015 The block SHALL have port busy, output, 1 bit: a word is being serialized.
REQ-016 The block SHALL have port word_done, output, 1 bit: one-cycle strobe at the end of each word.
REQ-017 The block SHALL have port overflow, output, 1 bit: sticky flag for a write attempted while full.

Function
REQ-018 On a push (in_valid && in_ready), the block SHALL store {K, ~K, K} with K = in_data[4:0] when raw_mode=0, or in_data[14:0] when raw_mode=1.
REQ-019 in_ready SHALL equal !full, with no same-cycle bypass: a push while full is refused even if a pop occurs in that cycle.
REQ-020 overflow SHALL set on in_valid && !in_ready, and SHALL clear only on reset or abort.
REQ-021 The FSM SHALL have exactly three states: IDLE, PULSE and GAP.
REQ-022 In IDLE with the FIFO not empty and BLKUPL_n=1, the block SHALL pop the head word into a 15-bit shift register, set bit_cnt=14, and enter PULSE on the next cycle; UPL0/UPL1 SHALL rise on that next cycle.
REQ-023 In PULSE, UPL1 SHALL equal shift[14] and UPL0 SHALL equal ~shift[14] for exactly PULSE_CYC cycles, after which the block SHALL enter GAP.
REQ-024 In GAP, both UPL0 and UPL1 SHALL be 0 for at least GAP_CYC cycles.
REQ-025 At the end of GAP with bit_cnt=0, the block SHALL pulse word_done for 1 cycle and return to IDLE.
REQ-026 At the end of GAP with bit_cnt>0, the block SHALL shift left by 1 and decrement bit_cnt; it SHALL enter PULSE if BLKUPL_n=1, otherwise remain in GAP until BLKUPL_n=1.
REQ-027 BLKUPL_n SHALL never truncate a pulse already in progress; it acts only between bits and before a word starts.
REQ-028 UPL0 and UPL1 SHALL never both be 1, and both SHALL be registered outputs.
REQ-029 busy SHALL be 1 exactly when the state is not IDLE.
REQ-030 With the FIFO non-empty and no block, consecutive words SHALL be separated by exactly 1 IDLE cycle.
REQ-031 abort SHALL take priority over everything: empty the FIFO, clear overflow, force IDLE, and drive UPL0=UPL1=0 from the next cycle; a push in the same cycle SHALL be discarded.
REQ-032 The FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH, and an occupancy counter SHALL distinguish full from empty.

Reset
REQ-033 While SIM_RST_n=0, the block SHALL asynchronously force state=IDLE, FIFO empty, UPL0=0, UPL1=0, busy=0, word_done=0, overflow=0, and in_ready=1.
REQ-034 Deasserting reset mid-word SHALL NOT resume the interrupted word; the block SHALL restart from an empty FIFO.

Verification
REQ-035 Keycode 5'b10101 pushed with raw_mode=0 -> pulse sequence 1,0,1,0,1, 0,1,0,1,0, 1,0,1,0,1 on UPL1/UPL0, each pulse 20 cycles wide with 80-cycle gaps; word_done 1500 cycles after the first pulse rises.
REQ-036 Raw word 15'h7FFF followed by 15'h0000 -> 15 UPL1 pulses, 1 idle cycle, then 15 UPL0 pulses; UPL0 is never high during the first word.
REQ-037 5 pushes in consecutive cycles while idle -> pushes 1-5 all accepted, because the first word pops from the FIFO the cycle after its push and frees a slot; a 6th consecutive push -> in_ready=0 and overflow=1 until abort.
REQ-038 BLKUPL_n=0 asserted during bit 3's pulse -> bit 3's pulse completes its full 20 cycles; bit 4 does not start until 1 cycle after BLKUPL_n returns to 1.
REQ-039 abort asserted during bit 7 with 2 words queued -> UPL0=UPL1=0 and busy=0 on the next cycle, FIFO empty, and no word_done strobe.
REQ-040 SIM_RST_n pulled low mid-pulse -> UPL0/UPL1 drop immediately (asynchronously); after release, no pulses are issued until a new push.
